// File: rtl/rgb_to_ypbpr_pkg.sv
// rgb_to_ypbpr_pkg: conversion coefficients, chroma offset and channel expansion helper
package rgb_to_ypbpr_pkg;
  localparam int Y_R  = 77;
  localparam int Y_G  = 150;
  localparam int Y_B  = 29;
  localparam int PB_R = -43;
  localparam int PB_G = -85;
  localparam int PB_B = 128;
  localparam int PR_R = 128;
  localparam int PR_G = -107;
  localparam int PR_B = -21;
  localparam int C_OFS = 32768;
  function automatic logic [7:0] expand8(input logic [7:0] x, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = x[w-1-(i%w)];
    return r;
  endfunction
endpackage

// File: rtl/rgb_to_ypbpr_mac3.sv
// ypbpr_mac3: three registered constant products, then offset add and clamp to 8 bits
module ypbpr_mac3 #(
  parameter int C0  = 0,
  parameter int C1  = 0,
  parameter int C2  = 0,
  parameter int OFS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] y
);
  logic signed [17:0] p0_d, p1_d, p2_d, p0_q, p1_q, p2_q;
  logic signed [19:0] sum;
  logic signed [11:0] hi;
  always_comb begin
    p0_d = $signed(18'(C0)) * $signed({10'b0, a});
    p1_d = $signed(18'(C1)) * $signed({10'b0, b});
    p2_d = $signed(18'(C2)) * $signed({10'b0, c});
    sum  = 20'(p0_q) + 20'(p1_q) + 20'(p2_q) + $signed(20'(OFS));
    hi   = 12'(sum >>> 8);
    y    = hi[11] ? 8'd0 : (hi > 12'sd255 ? 8'd255 : hi[7:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      p0_q <= p0_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end
endmodule

// File: rtl/rgb_to_ypbpr.sv
// rgb_to_ypbpr: two-stage RGB to YPbPr converter with same-latency RGB/sync bypass
module rgb_to_ypbpr
  import rgb_to_ypbpr_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] red_in,
  input  logic [WIDTH-1:0] green_in,
  input  logic [WIDTH-1:0] blue_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             cs_in,
  output logic [WIDTH-1:0] red_out,
  output logic [WIDTH-1:0] green_out,
  output logic [WIDTH-1:0] blue_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             cs_out
);
  logic [7:0] r8, g8, b8, y8, pb8, pr8;
  logic [WIDTH-1:0] r_s1_q, g_s1_q, b_s1_q;
  logic ena_s1_q, hs_s1_q, vs_s1_q, cs_s1_q;
  logic [WIDTH-1:0] red_d, green_d, blue_d, red_q, green_q, blue_q;
  logic hs_q, vs_q, cs_q;
  assign r8 = expand8(8'(red_in), WIDTH);
  assign g8 = expand8(8'(green_in), WIDTH);
  assign b8 = expand8(8'(blue_in), WIDTH);
  ypbpr_mac3 #(.C0(Y_R), .C1(Y_G), .C2(Y_B), .OFS(0)) u_y (
    .clk(clk), .rst(rst), .a(r8), .b(g8), .c(b8), .y(y8)
  );
  ypbpr_mac3 #(.C0(PB_R), .C1(PB_G), .C2(PB_B), .OFS(C_OFS)) u_pb (
    .clk(clk), .rst(rst), .a(r8), .b(g8), .c(b8), .y(pb8)
  );
  ypbpr_mac3 #(.C0(PR_R), .C1(PR_G), .C2(PR_B), .OFS(C_OFS)) u_pr (
    .clk(clk), .rst(rst), .a(r8), .b(g8), .c(b8), .y(pr8)
  );
  always_comb begin
    red_d   = ena_s1_q ? pr8[7-:WIDTH] : r_s1_q;
    green_d = ena_s1_q ? y8[7-:WIDTH]  : g_s1_q;
    blue_d  = ena_s1_q ? pb8[7-:WIDTH] : b_s1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_s1_q, g_s1_q, b_s1_q} <= '0;
      {ena_s1_q, hs_s1_q, vs_s1_q, cs_s1_q} <= '0;
      {red_q, green_q, blue_q} <= '0;
      {hs_q, vs_q, cs_q} <= '0;
    end else begin
      {r_s1_q, g_s1_q, b_s1_q} <= {red_in, green_in, blue_in};
      {ena_s1_q, hs_s1_q, vs_s1_q, cs_s1_q} <= {ena, hs_in, vs_in, cs_in};
      {red_q, green_q, blue_q} <= {red_d, green_d, blue_d};
      {hs_q, vs_q, cs_q} <= {hs_s1_q, vs_s1_q, cs_s1_q};
    end
  end
  assign red_out   = red_q;
  assign green_out = green_q;
  assign blue_out  = blue_q;
  assign hs_out    = hs_q;
  assign vs_out    = vs_q;
  assign cs_out    = cs_q;
endmodule

// File: tb/tb_rgb_to_ypbpr.sv
// tb_rgb_to_ypbpr: random and directed stimulus against an arithmetic reference model
module tb_rgb_to_ypbpr;
  localparam int W = 6;
  logic clk = 0, rst = 1, ena = 0;
  logic [W-1:0] ri = '0, gi = '0, bi = '0;
  logic hsi = 0, vsi = 0, csi = 0;
  logic [W-1:0] ro, go, bo;
  logic hso, vso, cso;
  int n_chk = 0, n_pass = 0;
  typedef struct packed {
    logic rst;
    logic ena;
    logic [W-1:0] r, g, b;
    logic hs, vs, cs;
  } smp_t;
  smp_t cur = '{rst: 1'b1, default: '0};
  smp_t prv = '{rst: 1'b1, default: '0};
  always #5 clk = ~clk;
  rgb_to_ypbpr #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .red_in(ri), .green_in(gi), .blue_in(bi),
    .hs_in(hsi), .vs_in(vsi), .cs_in(csi),
    .red_out(ro), .green_out(go), .blue_out(bo),
    .hs_out(hso), .vs_out(vso), .cs_out(cso)
  );
  function automatic int exp8(int x);
    return ((x << (8 - W)) | (x >> (2 * W - 8))) & 255;
  endfunction
  function automatic int clamp(int v);
    return v < 0 ? 0 : (v > 255 ? 255 : v);
  endfunction
  function automatic logic [3*W+2:0] model(smp_t s);
    int r8, g8, b8, y, pb, pr;
    r8 = exp8(int'(s.r));
    g8 = exp8(int'(s.g));
    b8 = exp8(int'(s.b));
    y  = clamp((77 * r8 + 150 * g8 + 29 * b8) >>> 8);
    pb = clamp((32768 - 43 * r8 - 85 * g8 + 128 * b8) >>> 8);
    pr = clamp((32768 + 128 * r8 - 107 * g8 - 21 * b8) >>> 8);
    if (s.rst) return '0;
    if (!s.ena) return {s.r, s.g, s.b, s.hs, s.vs, s.cs};
    return {W'(pr >>> (8 - W)), W'(y >>> (8 - W)), W'(pb >>> (8 - W)), s.hs, s.vs, s.cs};
  endfunction
  task automatic chk(string nm, logic [3*W+2:0] got, logic [3*W+2:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
  endtask
  always @(posedge clk) begin
    prv = cur;
    cur = '{rst, ena, ri, gi, bi, hsi, vsi, csi};
  end
  always @(negedge clk) chk("pipe", {ro, go, bo, hso, vso, cso}, cur.rst ? '0 : model(prv));
  task automatic pin(string nm, int r, int g, int b, int ey, int epb, int epr);
    smp_t s;
    @(negedge clk);
    ena = 1; ri = W'(r); gi = W'(g); bi = W'(b); {hsi, vsi, csi} = '0;
    s = '{1'b0, 1'b1, W'(r), W'(g), W'(b), 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk({nm, "_dut"}, {3'b0, ro, go, bo}, {3'b0, W'(epr), W'(ey), W'(epb)});
    chk({nm, "_model"}, model(s), {W'(epr), W'(ey), W'(epb), 3'b0});
  endtask
  task automatic rnd();
    {ri, gi, bi} = 3 * W'($urandom);
    ri = W'($urandom); gi = W'($urandom); bi = W'($urandom);
    {hsi, vsi, csi} = 3'($urandom);
  endtask
  initial begin
    repeat (4) begin
      @(negedge clk);
      rnd();
      ena = 1'($urandom);
      chk("reset", {ro, go, bo, hso, vso, cso}, '0);
    end
    @(negedge clk);
    rst = 0;
    pin("white", 63, 63, 63, 63, 32, 32);
    pin("black", 0, 0, 0, 0, 32, 32);
    pin("red", 63, 0, 0, 19, 21, 63);
    pin("green", 0, 63, 0, 37, 10, 5);
    pin("blue", 0, 0, 63, 7, 63, 26);
    repeat (300) begin
      @(negedge clk);
      rnd();
      if ($urandom_range(7) == 0) ena = ~ena;
    end
    ena = 0;
    repeat (200) begin
      @(negedge clk);
      rnd();
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ri = W'(i); gi = W'(i); bi = W'(63 - i);
      hsi = (i % 16) < 4;
      vsi = 0; csi = hsi;
      if (i == 20 || i == 41 || i == 42) ena = ~ena;
    end
    for (int m = 0; m < 2; m++) begin
      ena = 1'(m);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        rnd();
        hsi = (i % 5) == 0;
        vsi = (i % 7) == 1;
        csi = (i % 6) == 2;
      end
    end
    @(negedge clk);
    rst = 1;
    rnd();
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (20) begin
      @(negedge clk);
      rnd();
      ena = 1'($urandom);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rgb_to_ypbpr.md
Name: rgb_to_ypbpr

Overview:
- Converts a WIDTH-bit-per-channel RGB video stream plus its syncs into analog-component YPbPr levels.
- Sits after the OSD mixer and before the video DAC pins.
- When conversion is disabled, it passes RGB and syncs through with the same latency, so timing never changes with the mode.

Parameters:
- WIDTH, 6, bits per colour channel on inputs and outputs; legal range 4..8.

Ports:
- clk  in  1  pixel/video clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  1 = output YPbPr, 0 = RGB pass-through; sampled every cycle.
- red_in  in  WIDTH  red component.
- green_in  in  WIDTH  green component.
- blue_in  in  WIDTH  blue component.
- hs_in  in  1  horizontal sync.
- vs_in  in  1  vertical sync.
- cs_in  in  1  composite sync.
- red_out  out  WIDTH  Pr when ena, else red.
- green_out  out  WIDTH  Y when ena, else green.
- blue_out  out  WIDTH  Pb when ena, else blue.
- hs_out  out  1  hs_in delayed.
- vs_out  out  1  vs_in delayed.
- cs_out  out  1  cs_in delayed.

Behaviour:
- Reset: every pipeline register and every output is 0 while rst=1. The first valid output appears 2 cycles after rst deasserts.
- Latency: exactly 2 clk cycles from input to output for colour and all three syncs, in both modes.
- ena is sampled in stage 1 and carried down the pipeline with its data. A toggle therefore affects output 2 cycles later, with no mixed-mode samples.
- Pass-through (ena=0): outputs equal inputs from 2 cycles earlier, bit-exact.
- Expansion: each input is widened to 8 bits by MSB replication. Example for WIDTH=6: {x, x[5:4]}.
- Conversion, using 8-bit values R, G, B and unsigned 17-bit arithmetic:
  - Y  = (77R + 150G + 29B) >> 8
  - Pb = (32768 − 43R − 85G + 128B) >> 8
  - Pr = (32768 + 128R − 107G − 21B) >> 8
- Range: the coefficients guarantee every intermediate lies in 0..65408, so no underflow or overflow occurs. Each result is 8 bits, 0..255. A clamp to 0..255 is still required as a safety net.
- Output word: the top WIDTH bits of each 8-bit result (truncation, no rounding).
- Stage 1 registers: the 9 coefficient products, the ena bit and the syncs.
- Stage 2 registers: offset addition, shift, clamp and the output/bypass mux.
- Syncs are delayed identically whatever ena is; they are never inverted or altered.

Decomposition:
- Package rgb_to_ypbpr_pkg holds:
  - localparams for the 9 coefficients and the 32768 offset;
  - a function to expand WIDTH to 8 bits.
- One sub-module, ypbpr_mac3:
  - 3 constant-coefficient products registered in stage 1, signed add plus offset in stage 2, clamped 8-bit result;
  - instantiated three times, once each for Y, Pb and Pr.

Test Plan:
- Reset: rst=1 with random inputs → all outputs 0. Release rst → outputs track inputs after exactly 2 cycles.
- ena=1, WIDTH=6, white (63,63,63) → green_out=63, blue_out=32, red_out=32. Black (0,0,0) → 0/32/32.
- ena=1, primaries:
  - red (63,0,0) → Y=19, Pb=21, Pr=63;
  - green (0,63,0) → Y=37, Pb=10, Pr=5;
  - blue (0,0,63) → Y=7, Pb=63, Pr=26.
- ena=0, random RGB and sync patterns → outputs are bit-exact copies of inputs delayed 2 cycles.
- Toggle ena mid-line with a pixel ramp → the mode switch lands exactly 2 cycles later. Sync outputs show no glitch and no extra delay across the switch.
- Sync timing: hs_in/vs_in/cs_in single-cycle pulses in both modes → each pulse appears on its output 2 cycles later, aligned with the colour data of the same input cycle.
